// File: rtl/cp0_regfile_pkg.sv
// Shared definitions for the CP0 register file: exception type encodings
// driven by exception detection, CP0 register numbers, field positions,
// reset values and MTC0 write masks.
package cp0_regfile_pkg;

  typedef enum logic [31:0] {
    EXC_NOEXC = 32'h0000_0000,
    EXC_INT   = 32'h0000_0001,
    EXC_ADEL  = 32'h0000_0004,
    EXC_ADES  = 32'h0000_0005,
    EXC_SYS   = 32'h0000_0008,
    EXC_BP    = 32'h0000_0009,
    EXC_RI    = 32'h0000_000A,
    EXC_OV    = 32'h0000_000C,
    EXC_ERET  = 32'h0000_000E
  } exc_type_e;

  // CP0 register numbers
  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;
  localparam logic [4:0] CP0_PRID     = 5'd15;

  // Field positions
  localparam int unsigned STATUS_IE    = 0;
  localparam int unsigned STATUS_EXL   = 1;
  localparam int unsigned STATUS_IM_LO = 8;
  localparam int unsigned CAUSE_EXC_LO = 2;
  localparam int unsigned CAUSE_IP_LO  = 8;
  localparam int unsigned CAUSE_TI     = 30;
  localparam int unsigned CAUSE_BD     = 31;

  // Reset value and write masks
  localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

  function automatic logic [4:0] exc_code(input logic [31:0] exc_type);
    case (exc_type)
      EXC_INT:  exc_code = 5'd0;
      EXC_ADEL: exc_code = 5'd4;
      EXC_ADES: exc_code = 5'd5;
      EXC_SYS:  exc_code = 5'd8;
      EXC_BP:   exc_code = 5'd9;
      EXC_RI:   exc_code = 5'd10;
      EXC_OV:   exc_code = 5'd12;
      default:  exc_code = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/cp0_regfile_timer.sv
// CP0 Count/Compare timer.
// Ports: clk/rst (sync, active-high); count_we/compare_we with wdata load
// the registers (already qualified by the caller); count, compare and
// timer_int are the current register values.
module cp0_timer #(
  parameter bit COUNT_HALF_RATE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_int
);

  logic toggle;

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      compare   <= '0;
      timer_int <= 1'b0;
      toggle    <= 1'b0;
    end else begin
      // The toggle keeps its rhythm across Count writes.
      toggle <= ~toggle;

      if (count_we)
        count <= wdata;
      else if (!COUNT_HALF_RATE || toggle)
        count <= count + 32'd1;

      // A Compare write acknowledges the interrupt and beats a same-cycle match.
      if (compare_we) begin
        compare   <= wdata;
        timer_int <= 1'b0;
      end else if (count == compare) begin
        timer_int <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_regfile.sv
// CP0 register file in the MEM stage: commits exceptions into
// Status/Cause/EPC/BadVAddr, services MTC0/MFC0 and hosts the timer.
// Ports: clk/rst (sync, active-high); we_i/waddr_i/wdata_i MTC0 write;
// raddr_i/rdata_o MFC0 read (combinational, with write bypass);
// ext_int_i hardware interrupts; except_type_i/pc_i/in_delayslot_i/
// badvaddr_i exception commit inputs; *_o current register values;
// timer_int_o is Cause.TI.
module cp0_regfile
  import cp0_regfile_pkg::*;
#(
  parameter logic [31:0] PRID_VALUE      = 32'h0000_4220,
  parameter bit          COUNT_HALF_RATE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_i,
  output logic [31:0] rdata_o,
  input  logic [5:0]  ext_int_i,
  input  logic [31:0] except_type_i,
  input  logic [31:0] pc_i,
  input  logic        in_delayslot_i,
  input  logic [31:0] badvaddr_i,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] badvaddr_o,
  output logic        timer_int_o
);

  logic [7:0]  im;
  logic        exl;
  logic        ie;
  logic        bd;
  logic [4:0]  exccode;
  logic [5:0]  ip_hw;
  logic [1:0]  ip_sw;
  logic [31:0] epc;
  logic [31:0] badvaddr;

  logic        exc_commit;
  logic        eret;
  logic        mtc0;
  logic        addr_err;
  logic        bypass;
  logic [31:0] status_wr;
  logic [31:0] cause_wr;

  assign exc_commit = (except_type_i != EXC_NOEXC) && (except_type_i != EXC_ERET);
  assign eret       = (except_type_i == EXC_ERET);
  // An exception or ERET in the same cycle swallows the MTC0 entirely.
  assign mtc0       = we_i && !exc_commit && !eret;
  assign addr_err   = (except_type_i == EXC_ADEL) || (except_type_i == EXC_ADES);

  cp0_timer #(
    .COUNT_HALF_RATE(COUNT_HALF_RATE)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (mtc0 && (waddr_i == CP0_COUNT)),
    .compare_we (mtc0 && (waddr_i == CP0_COMPARE)),
    .wdata      (wdata_i),
    .count      (count_o),
    .compare    (compare_o),
    .timer_int  (timer_int_o)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      im       <= '0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      exccode  <= '0;
      ip_hw    <= '0;
      ip_sw    <= '0;
      epc      <= '0;
      badvaddr <= '0;
    end else begin
      ip_hw <= {ext_int_i[5] | timer_int_o, ext_int_i[4:0]};

      if (exc_commit) begin
        exl     <= 1'b1;
        exccode <= exc_code(except_type_i);
        // A nested exception keeps the original return point.
        if (!exl) begin
          bd  <= in_delayslot_i;
          epc <= in_delayslot_i ? (pc_i - 32'd4) : pc_i;
        end
        if (addr_err)
          badvaddr <= badvaddr_i;
      end else if (eret) begin
        exl <= 1'b0;
      end else if (mtc0) begin
        case (waddr_i)
          CP0_STATUS: begin
            im  <= wdata_i[STATUS_IM_LO +: 8];
            exl <= wdata_i[STATUS_EXL];
            ie  <= wdata_i[STATUS_IE];
          end
          CP0_CAUSE: ip_sw <= wdata_i[CAUSE_IP_LO +: 2];
          CP0_EPC:   epc   <= wdata_i;
          default: ;
        endcase
      end
    end
  end

  assign status_o   = STATUS_RESET | {16'h0, im, 6'h0, exl, ie};
  assign cause_o    = {bd, timer_int_o, 14'h0, ip_hw, ip_sw, 1'b0, exccode, 2'b00};
  assign epc_o      = epc;
  assign badvaddr_o = badvaddr;

  assign status_wr = (status_o & ~STATUS_WMASK) | (wdata_i & STATUS_WMASK);
  assign cause_wr  = (cause_o & ~CAUSE_WMASK) | (wdata_i & CAUSE_WMASK);
  assign bypass    = we_i && (waddr_i == raddr_i);

  always_comb begin
    rdata_o = '0;
    case (raddr_i)
      CP0_BADVADDR: rdata_o = badvaddr;
      CP0_COUNT:    rdata_o = bypass ? wdata_i : count_o;
      CP0_COMPARE:  rdata_o = bypass ? wdata_i : compare_o;
      CP0_STATUS:   rdata_o = bypass ? status_wr : status_o;
      CP0_CAUSE:    rdata_o = bypass ? cause_wr : cause_o;
      CP0_EPC:      rdata_o = bypass ? wdata_i : epc;
      CP0_PRID:     rdata_o = PRID_VALUE;
      default:      rdata_o = '0;
    endcase
  end

endmodule
